// File: rtl/audio_adc_rx.sv
// audio_adc_rx: codec ADC serial receiver (BCK/LRCK/DAT, MSB first, left-justified).
// Ports: iCLK_18_4/iRST_N, codec inputs, stereo frame out with valid/ack, sticky flags.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_ADCLRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] oLEFT_DATA,
  output logic [DATA_WIDTH-1:0] oRIGHT_DATA,
  output logic                  oDATA_VALID,
  input  logic                  iDATA_ACK,
  output logic                  oOVERRUN,
  output logic                  oSHORT_ERR,
  input  logic                  iERR_CLR
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    WAIT_SYNC,
    RX_LEFT,
    RX_RIGHT
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bck_d;
  logic                   lr_d;
  logic [SYNC_STAGES:0]   prime;

  logic bck_s, lr_s, dat_s, primed;
  logic bck_rise, lr_rise, lr_fall, lr_edge;

  logic start_left, end_left, end_right, capture;
  logic word_start, short_set, ovr_set;

  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [DATA_WIDTH-1:0] right_hold;
  logic                  pub_q;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_sync <= '0;
      lr_sync  <= '0;
      dat_sync <= '0;
      bck_d    <= 1'b0;
      lr_d     <= 1'b0;
      prime    <= '0;
    end else begin
      bck_sync <= {bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
      lr_sync  <= {lr_sync[SYNC_STAGES-2:0], iAUD_ADCLRCK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
      bck_d    <= bck_sync[SYNC_STAGES-1];
      lr_d     <= lr_sync[SYNC_STAGES-1];
      prime    <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign bck_s = bck_sync[SYNC_STAGES-1];
  assign lr_s  = lr_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // The zeroed synchronizers would fake an LRCK rise right after reset
  // when LRCK is high; edges count only once the chain holds real samples.
  assign primed = prime[SYNC_STAGES];

  assign bck_rise = primed & bck_s & ~bck_d;
  assign lr_rise  = primed & lr_s & ~lr_d;
  assign lr_fall  = primed & ~lr_s & lr_d;
  assign lr_edge  = lr_rise | lr_fall;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) state <= WAIT_SYNC;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_SYNC: if (lr_rise) state_nx = RX_LEFT;
      RX_LEFT:   if (lr_edge) state_nx = RX_RIGHT;
      RX_RIGHT:  if (lr_edge) state_nx = RX_LEFT;
      default:   state_nx = WAIT_SYNC;
    endcase
  end

  always_comb begin
    start_left = 1'b0;
    end_left   = 1'b0;
    end_right  = 1'b0;
    capture    = 1'b0;
    unique case (state)
      WAIT_SYNC: start_left = lr_rise;
      RX_LEFT: begin
        end_left = lr_edge;
        capture  = 1'b1;
      end
      RX_RIGHT: begin
        end_right = lr_edge;
        capture   = 1'b1;
      end
      default: ;
    endcase
  end

  assign word_start = start_left | end_left | end_right;
  assign bit_mask   = MSB_ONE >> cnt;
  assign short_set  = (end_left | end_right) & (cnt < CNT_FULL);

  // A BCK rise coinciding with an LRCK edge is the new word's MSB.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      shift <= '0;
      cnt   <= '0;
    end else if (word_start) begin
      shift <= (bck_rise & dat_s) ? MSB_ONE : '0;
      cnt   <= bck_rise ? CW'(1) : '0;
    end else if (capture & bck_rise & (cnt < CNT_FULL)) begin
      if (dat_s) shift <= shift | bit_mask;
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      left_hold  <= '0;
      right_hold <= '0;
      pub_q      <= 1'b0;
    end else begin
      pub_q <= end_right;
      if (end_left)  left_hold  <= shift;
      if (end_right) right_hold <= shift;
    end
  end

  assign ovr_set = pub_q & oDATA_VALID & ~iDATA_ACK;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oLEFT_DATA  <= '0;
      oRIGHT_DATA <= '0;
      oDATA_VALID <= 1'b0;
      oOVERRUN    <= 1'b0;
      oSHORT_ERR  <= 1'b0;
    end else begin
      if (pub_q) begin
        oLEFT_DATA  <= left_hold;
        oRIGHT_DATA <= right_hold;
        oDATA_VALID <= 1'b1;
      end else if (iDATA_ACK & oDATA_VALID) begin
        oDATA_VALID <= 1'b0;
      end
      if (ovr_set)       oOVERRUN <= 1'b1;
      else if (iERR_CLR) oOVERRUN <= 1'b0;
      if (short_set)     oSHORT_ERR <= 1'b1;
      else if (iERR_CLR) oSHORT_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed bench for audio_adc_rx.
// Drives a slow BCK/LRCK/DAT stream and checks frames, handshake and flags.
`timescale 1ns/1ps
module tb_audio_adc_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bck = 1'b0;
  logic          lrck = 1'b0;
  logic          dat = 1'b0;
  logic          ack = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          valid;
  logic          overrun;
  logic          short_err;

  int tests = 0;
  int fails = 0;

  always #27 clk = ~clk;

  audio_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .iCLK_18_4   (clk),
    .iRST_N      (rst_n),
    .iAUD_BCK    (bck),
    .iAUD_ADCLRCK(lrck),
    .iAUD_ADCDAT (dat),
    .oLEFT_DATA  (left),
    .oRIGHT_DATA (right),
    .oDATA_VALID (valid),
    .iDATA_ACK   (ack),
    .oOVERRUN    (overrun),
    .oSHORT_ERR  (short_err),
    .iERR_CLR    (err_clr)
  );

  task automatic send_word(input logic lr, input logic [31:0] w,
                           input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bck = 1'b0;
      lrck = lr;
      dat = w[n-1-i];
      repeat (4) @(negedge clk);
      bck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic close_frame();
    @(negedge clk);
    bck = 1'b0;
    lrck = 1'b1;
    dat = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lrck = 1'b0;
    #100;
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b want 0", valid);
    end
    tests++;
    if (left !== 16'h0 || right !== 16'h0) begin
      fails++;
      $display("FAIL reset_data got %h/%h want 0/0", left, right);
    end
    tests++;
    if (overrun !== 1'b0 || short_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got %b%b want 00", overrun, short_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sync_discard();
    int first;
    send_word(1'b0, 32'hFF, 8);
    send_word(1'b1, 32'hA5C3, 16);
    send_word(1'b0, 32'h5A3C, 16);
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL discard_valid got %b want 0", valid);
    end
    tests++;
    if (short_err !== 1'b0) begin
      fails++;
      $display("FAIL discard_short got %b want 0", short_err);
    end
    close_frame();
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && first == 0) first = k;
    end
    tests++;
    if (first != 4) begin
      fails++;
      $display("FAIL sync_latency got %0d want 4", first);
    end
    tests++;
    if (left !== 16'hA5C3 || right !== 16'h5A3C) begin
      fails++;
      $display("FAIL sync_data got %h/%h want a5c3/5a3c", left, right);
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL sync_ack got %b want 0", valid);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL sync_single got %b want 0", valid);
    end
  endtask

  task automatic test_stream_handshake();
    logic [15:0] ls [3];
    logic [15:0] rs [3];
    ls = '{16'h1234, 16'h8000, 16'h0001};
    rs = '{16'hFEDC, 16'h7FFF, 16'hFFFF};
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          send_word(1'b1, {16'h0, ls[i]}, 16);
          send_word(1'b0, {16'h0, rs[i]}, 16);
        end
        close_frame();
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int c;
          c = 0;
          while (valid !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
          end
          tests++;
          if (valid !== 1'b1) begin
            fails++;
            $display("FAIL stream_timeout frame %0d got %b want 1", i, valid);
          end
          tests++;
          if (left !== ls[i] || right !== rs[i]) begin
            fails++;
            $display("FAIL stream_data frame %0d got %h/%h want %h/%h",
                     i, left, right, ls[i], rs[i]);
          end
          @(negedge clk);
          @(negedge clk);
          ack = 1'b1;
          @(negedge clk);
          ack = 1'b0;
          tests++;
          if (valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_ack frame %0d got %b want 0", i, valid);
          end
        end
      end
    join
    tests++;
    if (overrun !== 1'b0 || short_err !== 1'b0) begin
      fails++;
      $display("FAIL stream_flags got %b%b want 00", overrun, short_err);
    end
  endtask

  task automatic test_overrun();
    send_word(1'b1, 32'h1111, 16);
    send_word(1'b0, 32'h2222, 16);
    send_word(1'b1, 32'h3333, 16);
    send_word(1'b0, 32'h4444, 16);
    close_frame();
    repeat (8) @(negedge clk);
    tests++;
    if (valid !== 1'b1 || left !== 16'h3333 || right !== 16'h4444) begin
      fails++;
      $display("FAIL ovr_data got %b %h/%h want 1 3333/4444",
               valid, left, right);
    end
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_flag got %b want 1", overrun);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_clr got ovr=%b valid=%b want 0 1", overrun, valid);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_ack_collision();
    send_word(1'b1, 32'h5555, 16);
    send_word(1'b0, 32'h6666, 16);
    send_word(1'b1, 32'h7777, 16);
    send_word(1'b0, 32'h8888, 16);
    tests++;
    if (valid !== 1'b1 || left !== 16'h5555) begin
      fails++;
      $display("FAIL coll_pre got %b %h want 1 5555", valid, left);
    end
    close_frame();
    repeat (3) @(posedge clk);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL coll_valid got %b want 1", valid);
    end
    tests++;
    if (left !== 16'h7777 || right !== 16'h8888) begin
      fails++;
      $display("FAIL coll_data got %h/%h want 7777/8888", left, right);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL coll_ovr got %b want 0", overrun);
    end
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL coll_hold got %b want 1", valid);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_length_err();
    send_word(1'b1, 32'hABC, 12);
    send_word(1'b0, 32'h12345, 20);
    close_frame();
    repeat (8) @(negedge clk);
    tests++;
    if (valid !== 1'b1 || left !== 16'hABC0 || right !== 16'h1234) begin
      fails++;
      $display("FAIL len_data got %b %h/%h want 1 abc0/1234",
               valid, left, right);
    end
    tests++;
    if (short_err !== 1'b1) begin
      fails++;
      $display("FAIL len_short got %b want 1", short_err);
    end
    ack = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    err_clr = 1'b0;
    tests++;
    if (short_err !== 1'b0) begin
      fails++;
      $display("FAIL len_clr got %b want 0", short_err);
    end
    send_word(1'b1, 32'h1357, 16);
    send_word(1'b0, 32'h2468A, 20);
    close_frame();
    repeat (8) @(negedge clk);
    tests++;
    if (left !== 16'h1357 || right !== 16'h2468 || short_err !== 1'b0) begin
      fails++;
      $display("FAIL len_long got %h/%h short=%b want 1357/2468 0",
               left, right, short_err);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_async_reset();
    send_word(1'b1, 32'hFF, 8);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #0.5;
    tests++;
    if (valid !== 1'b0 || left !== 16'h0 || right !== 16'h0) begin
      fails++;
      $display("FAIL rst_outputs got %b %h/%h want 0 0/0", valid, left, right);
    end
    #0.5 rst_n = 1'b1;
    send_word(1'b1, 32'hFF, 8);
    send_word(1'b0, 32'hBEEF, 16);
    close_frame();
    repeat (8) @(negedge clk);
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_discard got %b want 0", valid);
    end
    tests++;
    if (short_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_short got %b want 0", short_err);
    end
    send_word(1'b1, 32'h0F0F, 16);
    send_word(1'b0, 32'hF0F0, 16);
    close_frame();
    repeat (8) @(negedge clk);
    tests++;
    if (valid !== 1'b1 || left !== 16'h0F0F || right !== 16'hF0F0) begin
      fails++;
      $display("FAIL rst_frame got %b %h/%h want 1 0f0f/f0f0",
               valid, left, right);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync_discard();
    test_stream_handshake();
    test_overrun();
    test_ack_collision();
    test_length_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(54 * 40000);
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
